// File: rtl/rc_osc_freq_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rc_osc_freq_monitor: enables the RC oscillator and counts its edges over  |
// | a fixed gate window, then reports the count and range/dead flags.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rc_osc_freq_monitor #(
  parameter int GATE_CYCLES    = 1000,
  parameter int STARTUP_CYCLES = 256,
  parameter int CNT_W          = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic             osc_in,
  output logic             osc_ena,
  input  logic [CNT_W-1:0] min_count,
  input  logic [CNT_W-1:0] max_count,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             busy,
  output logic             in_range,
  output logic             dead
);

  localparam int c_TMR_MAX = (GATE_CYCLES > STARTUP_CYCLES) ? GATE_CYCLES : STARTUP_CYCLES;
  localparam int c_TMR_W   = (c_TMR_MAX > 2) ? $clog2(c_TMR_MAX) : 1;
  localparam logic [c_TMR_W-1:0] c_GATE_LOAD  = c_TMR_W'(GATE_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_START_LOAD = c_TMR_W'(STARTUP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STARTUP = 2'd1,
    S_MEASURE = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [c_TMR_W-1:0]     r_tmr, w_tmr_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]       r_count;
  logic                   r_in_range, r_dead;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_rise, w_report, w_fin_in_range, w_fin_dead;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], osc_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_cnt_nxt   = r_cnt;
    w_report    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = S_STARTUP;
          w_tmr_nxt   = c_START_LOAD;
        end
      end
      S_STARTUP: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_tmr == '0) begin
          w_state_nxt = S_MEASURE;
          w_tmr_nxt   = c_GATE_LOAD;
          w_cnt_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr - c_TMR_W'(1);
        end
      end
      S_MEASURE: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          if (w_rise && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          if (r_tmr == '0) begin
            w_state_nxt = S_REPORT;
          end else begin
            w_tmr_nxt = r_tmr - c_TMR_W'(1);
          end
        end
      end
      S_REPORT: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_report = 1'b1;
          if (cont) begin
            w_state_nxt = S_MEASURE;
            w_tmr_nxt   = c_GATE_LOAD;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fin_in_range = (r_cnt >= min_count) && (r_cnt <= max_count);
  assign w_fin_dead     = (r_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count    <= '0;
      r_in_range <= 1'b0;
      r_dead     <= 1'b0;
    end else if (w_report) begin
      r_count    <= r_cnt;
      r_in_range <= w_fin_in_range;
      r_dead     <= w_fin_dead;
    end
  end

  // Results bypass the hold registers during REPORT so they appear with done,
  // while a coincident stop can still leave the previous results untouched.
  assign count    = w_report ? r_cnt          : r_count;
  assign in_range = w_report ? w_fin_in_range : r_in_range;
  assign dead     = w_report ? w_fin_dead     : r_dead;
  assign done     = w_report;
  assign busy     = (r_state != S_IDLE);
  assign osc_ena  = (r_state != S_IDLE);

endmodule
`default_nettype wire
